missile_launcher: RTL and testbench

- Initiator side of the missile launch interface; one instance per tank.
- Converts the player/AI fire request into a single-cycle `Missile_on` launch pulse, and computes the muzzle start point and direction from the tank pose.
- Holds the launch fields stable, tracks the missile through flight via `MissileDisplay`, then enforces a cooldown before the next shot.
- Sits between the tank controller and the missile block, clocked by the frame clock.

---
 rtl/tank_pkg.sv | 25 ++
 rtl/muzzle_calc.sv | 58 +++++
 rtl/missile_launcher.sv | 131 +++++++++++++
 tb/tb_missile_launcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank-game definitions: facing directions, field geometry, launcher states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tank_pkg;

    // Sprite edge length and exclusive upper bound of a valid field coordinate.
    localparam int TANK_SIZE = 16;
    localparam int FIELD_MAX = 256;

    // Facing encoding shared by the tank, launcher and missile blocks.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    // Launcher FSM encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LAUNCH   = 3'd1;
    localparam logic [2:0] ST_ACK      = 3'd2;
    localparam logic [2:0] ST_FLIGHT   = 3'd3;
    localparam logic [2:0] ST_COOLDOWN = 3'd4;

endpackage

// File: rtl/muzzle_calc.sv
// Muzzle point of a tank from its pose, plus a check that the point lies inside the field.
// Latency: combinational.
// Backpressure: none.
// Ports: i_x/i_y tank top-left, i_dir facing; o_x/o_y muzzle (low 10 bits), o_in_range.
module muzzle_calc
    import tank_pkg::*;
(
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [1:0] i_dir,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_in_range
);

    localparam logic signed [10:0] HALF = 11'(TANK_SIZE / 2 - 1);
    localparam logic signed [10:0] FAR  = 11'(TANK_SIZE + 1);
    localparam logic signed [10:0] TWO  = 11'sd2;
    localparam logic signed [10:0] FMAX = 11'(FIELD_MAX);

    logic signed [10:0] w_x;
    logic signed [10:0] w_y;
    logic signed [10:0] w_mx;
    logic signed [10:0] w_my;

    assign w_x = $signed({1'b0, i_x});
    assign w_y = $signed({1'b0, i_y});

    // Any overflow of the 11-bit sum wraps negative and therefore lands out of range.
    always_comb begin
        w_mx = w_x + HALF;
        w_my = w_y - TWO;
        case (i_dir)
            DIR_UP: begin
                w_mx = w_x + HALF;
                w_my = w_y - TWO;
            end
            DIR_LEFT: begin
                w_mx = w_x - TWO;
                w_my = w_y + HALF;
            end
            DIR_DOWN: begin
                w_mx = w_x + HALF;
                w_my = w_y + FAR;
            end
            default: begin
                w_mx = w_x + FAR;
                w_my = w_y + HALF;
            end
        endcase
    end

    assign o_x        = w_mx[9:0];
    assign o_y        = w_my[9:0];
    assign o_in_range = (w_mx > 11'sd0) && (w_mx < FMAX) &&
                        (w_my > 11'sd0) && (w_my < FMAX);

endmodule

// File: rtl/missile_launcher.sv
// Turns a fire-key rising edge into a one-frame launch pulse with latched muzzle fields,
// then tracks the missile through flight and enforces a cooldown before the next shot.
// Latency: launch pulse one frame after the sampled edge. Backpressure: fire edges outside IDLE are dropped.
// Ports: pose/fire/MissileDisplay in; Missile_on, Xstart/Ystart/MissileType, Ready, FireBlocked, AckErr, ShotCount out.
module missile_launcher
    import tank_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 20,
    parameter int ACK_TIMEOUT     = 4
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] TankDir,
    input  logic       TankAlive,
    input  logic       FireKey,
    input  logic       MissileDisplay,
    output logic       Missile_on,
    output logic [9:0] Xstart,
    output logic [9:0] Ystart,
    output logic [1:0] MissileType,
    output logic       Ready,
    output logic       FireBlocked,
    output logic       AckErr,
    output logic [7:0] ShotCount
);

    // One counter serves both the ACK timeout and the cooldown.
    localparam int CNT_W = (COOLDOWN_FRAMES > ACK_TIMEOUT) ? $clog2(COOLDOWN_FRAMES + 1)
                                                           : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fire_prev;
    logic [9:0]       r_xs;
    logic [9:0]       r_ys;
    logic [1:0]       r_type;
    logic             r_blocked;
    logic [7:0]       r_shots;

    logic       w_fire_rise;
    logic [9:0] w_mx;
    logic [9:0] w_my;
    logic       w_in_range;

    assign w_fire_rise = FireKey & ~r_fire_prev;

    muzzle_calc u_muzzle (
        .i_x        (TankX),
        .i_y        (TankY),
        .i_dir      (TankDir),
        .o_x        (w_mx),
        .o_y        (w_my),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_fire_prev <= 1'b0;
            r_xs        <= '0;
            r_ys        <= '0;
            r_type      <= '0;
            r_blocked   <= 1'b0;
            r_shots     <= '0;
        end else begin
            r_fire_prev <= FireKey;
            r_blocked   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire_rise && TankAlive) begin
                        if (w_in_range) begin
                            // Launch fields move only here so the missile samples stable values.
                            r_xs    <= w_mx;
                            r_ys    <= w_my;
                            r_type  <= TankDir;
                            r_state <= ST_LAUNCH;
                        end else begin
                            r_blocked <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_shots <= r_shots + 8'd1;
                    r_cnt   <= '0;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    // A late MissileDisplay on the timeout cycle still counts as an ack.
                    if (MissileDisplay) begin
                        r_state <= ST_FLIGHT;
                    end else if (r_cnt == ACK_LAST) begin
                        r_cnt   <= COOL_LOAD;
                        r_state <= ST_COOLDOWN;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_FLIGHT: begin
                    if (!MissileDisplay) begin
                        r_cnt   <= COOL_LOAD;
                        r_state <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Missile_on  = (r_state == ST_LAUNCH);
    assign Ready       = (r_state == ST_IDLE);
    assign AckErr      = (r_state == ST_ACK) && !MissileDisplay && (r_cnt == ACK_LAST);
    assign FireBlocked = r_blocked;
    assign Xstart      = r_xs;
    assign Ystart      = r_ys;
    assign MissileType = r_type;
    assign ShotCount   = r_shots;

endmodule

// File: tb/tb_missile_launcher.sv
// Directed bench for missile_launcher: pose/fire vector table plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_missile_launcher;
    import tank_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [9:0] TankX;
    logic [9:0] TankY;
    logic [1:0] TankDir;
    logic       TankAlive;
    logic       FireKey;
    logic       MissileDisplay;
    logic       Missile_on;
    logic [9:0] Xstart;
    logic [9:0] Ystart;
    logic [1:0] MissileType;
    logic       Ready;
    logic       FireBlocked;
    logic       AckErr;
    logic [7:0] ShotCount;

    missile_launcher dut (
        .frame_clk      (frame_clk),
        .Reset_n        (Reset_n),
        .TankX          (TankX),
        .TankY          (TankY),
        .TankDir        (TankDir),
        .TankAlive      (TankAlive),
        .FireKey        (FireKey),
        .MissileDisplay (MissileDisplay),
        .Missile_on     (Missile_on),
        .Xstart         (Xstart),
        .Ystart         (Ystart),
        .MissileType    (MissileType),
        .Ready          (Ready),
        .FireBlocked    (FireBlocked),
        .AckErr         (AckErr),
        .ShotCount      (ShotCount)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cyc, output int used);
        used = 0;
        while (Ready !== 1'b1 && used < max_cyc) begin
            tick();
            used++;
        end
    endtask

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic       alive;
        logic       launch;
        logic       blocked;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    logic [9:0] exp_x;
    logic [9:0] exp_y;
    logic [1:0] exp_t;
    int         exp_shots;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int used;
        int cyc;
        int pulses;
        int acks;
        int errs;
        logic saw;

        vecs[0]  = '{10'd100,  10'd100, DIR_UP,    1'b1, 1'b1, 1'b0, 10'd107, 10'd98};
        vecs[1]  = '{10'd0,    10'd100, DIR_LEFT,  1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[2]  = '{10'd239,  10'd100, DIR_RIGHT, 1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[3]  = '{10'd100,  10'd100, DIR_LEFT,  1'b1, 1'b1, 1'b0, 10'd98,  10'd107};
        vecs[4]  = '{10'd100,  10'd100, DIR_DOWN,  1'b1, 1'b1, 1'b0, 10'd107, 10'd117};
        vecs[5]  = '{10'd100,  10'd100, DIR_RIGHT, 1'b1, 1'b1, 1'b0, 10'd117, 10'd107};
        vecs[6]  = '{10'd238,  10'd50,  DIR_RIGHT, 1'b1, 1'b1, 1'b0, 10'd255, 10'd57};
        vecs[7]  = '{10'd50,   10'd1,   DIR_UP,    1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[8]  = '{10'd50,   10'd2,   DIR_UP,    1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[9]  = '{10'd50,   10'd3,   DIR_UP,    1'b1, 1'b1, 1'b0, 10'd57,  10'd1};
        vecs[10] = '{10'd100,  10'd100, DIR_UP,    1'b0, 1'b0, 1'b0, 10'd0,   10'd0};
        vecs[11] = '{10'd50,   10'd239, DIR_DOWN,  1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[12] = '{10'd50,   10'd238, DIR_DOWN,  1'b1, 1'b1, 1'b0, 10'd57,  10'd255};
        vecs[13] = '{10'd1000, 10'd100, DIR_UP,    1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[14] = '{10'd2,    10'd100, DIR_LEFT,  1'b1, 1'b0, 1'b1, 10'd0,   10'd0};
        vecs[15] = '{10'd3,    10'd100, DIR_LEFT,  1'b1, 1'b1, 1'b0, 10'd1,   10'd107};

        Reset_n        = 1'b0;
        TankX          = '0;
        TankY          = '0;
        TankDir        = '0;
        TankAlive      = 1'b1;
        FireKey        = 1'b0;
        MissileDisplay = 1'b0;
        exp_x          = '0;
        exp_y          = '0;
        exp_t          = '0;
        exp_shots      = 0;

        #12;
        chk("rst_missile_on", Missile_on, 0);
        chk("rst_xstart", Xstart, 0);
        chk("rst_ystart", Ystart, 0);
        chk("rst_type", MissileType, 0);
        chk("rst_ready", Ready, 1);
        chk("rst_blocked", FireBlocked, 0);
        chk("rst_ackerr", AckErr, 0);
        chk("rst_shots", ShotCount, 0);
        Reset_n = 1'b1;
        tick();
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            TankX     = vecs[i].x;
            TankY     = vecs[i].y;
            TankDir   = vecs[i].dir;
            TankAlive = vecs[i].alive;
            FireKey   = 1'b1;
            tick();
            if (vecs[i].launch) begin
                exp_x = vecs[i].ex;
                exp_y = vecs[i].ey;
                exp_t = vecs[i].dir;
            end
            chk($sformatf("v%0d_missile_on", i), Missile_on, vecs[i].launch);
            chk($sformatf("v%0d_blocked", i), FireBlocked, vecs[i].blocked);
            chk($sformatf("v%0d_ready", i), Ready, !vecs[i].launch);
            chk($sformatf("v%0d_xstart", i), Xstart, exp_x);
            chk($sformatf("v%0d_ystart", i), Ystart, exp_y);
            chk($sformatf("v%0d_type", i), MissileType, exp_t);
            FireKey = 1'b0;
            if (vecs[i].launch) begin
                // Pose changes after launch must not disturb the latched fields.
                TankX   = 10'd5;
                TankDir = ~vecs[i].dir;
                tick();
                exp_shots++;
                chk($sformatf("v%0d_pulse_width", i), Missile_on, 0);
                chk($sformatf("v%0d_shots", i), ShotCount, exp_shots & 255);
                tick();
                MissileDisplay = 1'b1;
                repeat (5) tick();
                MissileDisplay = 1'b0;
                wait_ready(60, used);
                chk($sformatf("v%0d_return_idle", i), Ready, 1);
                chk($sformatf("v%0d_xstart_held", i), Xstart, exp_x);
                chk($sformatf("v%0d_type_held", i), MissileType, exp_t);
            end else begin
                tick();
                chk($sformatf("v%0d_blocked_width", i), FireBlocked, 0);
                chk($sformatf("v%0d_ready_after", i), Ready, 1);
            end
            TankAlive = 1'b1;
        end

        // ---------------- flight then cooldown timing, fire during cooldown ----------------
        TankX = 10'd100; TankY = 10'd100; TankDir = DIR_UP;
        FireKey = 1'b1;
        tick();
        chk("cd_launch", Missile_on, 1);
        FireKey = 1'b0;
        tick();
        tick();
        MissileDisplay = 1'b1;
        repeat (30) tick();
        chk("cd_in_flight_not_ready", Ready, 0);
        MissileDisplay = 1'b0;
        exp_shots++;
        cyc = 0;
        saw = 1'b0;
        while (Ready !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (Missile_on) saw = 1'b1;
            if (cyc == 5) FireKey = 1'b1;
        end
        // One edge to sample the drop, then 20 cooldown frames.
        chk("cd_ready_edge_after_drop", cyc, 21);
        chk("cd_fire_in_cooldown_ignored", saw, 0);
        chk("cd_shots", ShotCount, exp_shots & 255);
        pulses = 0;
        repeat (10) begin
            tick();
            pulses += Missile_on;
        end
        chk("held_across_idle_no_fire", pulses, 0);
        FireKey = 1'b0;
        tick();

        // ---------------- ACK timeout ----------------
        FireKey = 1'b1;
        tick();
        FireKey = 1'b0;
        tick();
        chk("to_ack1_err", AckErr, 0);
        tick();
        tick();
        chk("to_ack3_err", AckErr, 0);
        tick();
        chk("to_ack4_err", AckErr, 1);
        tick();
        chk("to_err_width", AckErr, 0);
        chk("to_cooldown_not_ready", Ready, 0);
        wait_ready(40, used);
        chk("to_cooldown_len", used, 20);
        exp_shots++;

        // ---------------- ACK arrives on the timeout cycle ----------------
        FireKey = 1'b1;
        tick();
        FireKey = 1'b0;
        tick();
        tick();
        tick();
        tick();
        MissileDisplay = 1'b1;
        #1;
        chk("late_ack_no_err", AckErr, 0);
        tick();
        repeat (30) tick();
        chk("late_ack_went_flight", Ready, 0);
        MissileDisplay = 1'b0;
        wait_ready(40, used);
        chk("late_ack_idle", Ready, 1);
        exp_shots++;
        chk("late_ack_shots", ShotCount, exp_shots & 255);

        // ---------------- held key for 100 frames ----------------
        FireKey = 1'b1;
        pulses  = 0;
        acks    = 0;
        repeat (100) begin
            tick();
            pulses += Missile_on;
            acks   += AckErr;
        end
        chk("held_one_launch", pulses, 1);
        chk("held_one_ackerr", acks, 1);
        FireKey = 1'b0;
        exp_shots++;
        chk("held_shots", ShotCount, exp_shots & 255);
        tick();

        // ---------------- async reset mid-flight ----------------
        FireKey = 1'b1;
        tick();
        FireKey = 1'b0;
        tick();
        tick();
        MissileDisplay = 1'b1;
        repeat (5) tick();
        #3;
        Reset_n = 1'b0;
        #1;
        chk("midrst_ready", Ready, 1);
        chk("midrst_shots", ShotCount, 0);
        chk("midrst_xstart", Xstart, 0);
        chk("midrst_type", MissileType, 0);
        chk("midrst_on", Missile_on, 0);
        tick();
        tick();
        #2;
        Reset_n = 1'b1;
        MissileDisplay = 1'b0;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += Missile_on;
        end
        chk("midrst_no_pulse_after", pulses, 0);
        FireKey = 1'b1;
        tick();
        chk("postrst_launch", Missile_on, 1);
        FireKey = 1'b0;
        tick();
        chk("postrst_shots", ShotCount, 1);
        wait_ready(60, used);
        chk("postrst_idle", Ready, 1);

        // ---------------- ShotCount wrap ----------------
        errs = 0;
        for (int k = 0; k < 255; k++) begin
            FireKey = 1'b0;
            tick();
            FireKey = 1'b1;
            tick();
            FireKey = 1'b0;
            wait_ready(60, used);
            if (Ready !== 1'b1) errs++;
            if (k == 253) chk("wrap_shots_255", ShotCount, 255);
        end
        chk("wrap_no_stall", errs, 0);
        chk("wrap_shots_0", ShotCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
